uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 131 +++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: received payload, status flags
// and the read acknowledge.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 rd;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  rd,
    output data,
    output valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rd,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling FSM, single-entry
// output buffer with read acknowledge, framing-error pulse and sticky overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      clr_n,
  input  logic      rx,
  uart_rx_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;

  logic rx_meta_reg;
  logic rx_s_reg;
  logic rx_prev_reg;

  logic start_edge;
  logic stop_tick;
  logic byte_done;

  // Synchroniser plus one history flop for falling-edge detection; all idle high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  assign start_edge = rx_prev_reg & ~rx_s_reg;
  assign stop_tick  = (state_reg == STOP) && (cnt_reg == BIT_LAST);
  assign byte_done  = stop_tick & rx_s_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          bit_cnt_reg <= '0;
          if (start_edge) state_reg <= START;
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg   <= '0;
            state_reg <= rx_s_reg ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == DATA_LAST) begin
              bit_cnt_reg <= '0;
              state_reg   <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (stop_tick) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
            if (!rx_s_reg) frame_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase

      // A completing byte takes priority over a plain read; a read on the
      // completion cycle frees the buffer for the new byte.
      if (byte_done) begin
        if (!valid_reg || bus.rd) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (bus.rd && valid_reg) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end
    end
  end

  assign bus.data      = data_reg;
  assign bus.valid     = valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level schedule model checked every cycle,
// plus literal expectations for each scenario.
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int DB  = 8;
  // rx pin -> meta -> rx_s -> edge detect, then half bit + 9 bits to stop sample
  localparam int LAT = 3 + CPB / 2 + (DB + 1) * CPB;

  logic clk;
  logic clr_n;
  logic rx;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .rx    (rx),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned  at;
    logic [7:0]   b;
    logic         stop;
  } frame_t;

  frame_t      sched[$];
  frame_t      f;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_fe = 1'b0;
  logic        m_ov = 1'b0;
  logic        v_old;
  logic        hit;
  int unsigned rise_cyc = 0;
  logic        valid_seen = 1'b0;
  int          fe_count = 0;

  // Model: each scheduled frame resolves at its stop-sample edge.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_data  = '0;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      sched.delete();
    end else begin
      cyc++;
      m_fe  = 1'b0;
      v_old = m_valid;
      hit   = 1'b0;
      if (sched.size() > 0 && sched[0].at == cyc) begin
        f   = sched.pop_front();
        hit = 1'b1;
        if (!f.stop) m_fe = 1'b1;
        else if (!v_old || bus.rd) begin
          m_data  = f.b;
          m_valid = 1'b1;
        end else m_ov = 1'b1;
      end
      if (!(hit && f.stop) && bus.rd && v_old) begin
        m_valid = 1'b0;
        m_ov    = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_valid", int'(bus.valid), int'(m_valid));
    check("cyc_data", int'(bus.data), int'(m_data));
    check("cyc_frame_err", int'(bus.frame_err), int'(m_fe));
    check("cyc_overrun", int'(bus.overrun), int'(m_ov));
    if (bus.valid && !valid_seen) rise_cyc = cyc;
    valid_seen = bus.valid;
    if (bus.frame_err) fe_count++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    frame_t e;
    e.at = cyc + LAT;
    e.b = b;
    e.stop = stop;
    sched.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
    $display("frame 0x%02h stop=%0d: data=0x%02h valid=%0d fe_total=%0d overrun=%0d",
             b, stop, bus.data, bus.valid, fe_count, bus.overrun);
  endtask

  task automatic rd_pulse;
    bus.rd = 1'b1;
    idle(1);
    bus.rd = 1'b0;
    idle(1);
  endtask

  task automatic apply_reset;
    @(posedge clk);
    #3 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    idle(5);
  endtask

  int unsigned c0;
  int fe_base;

  initial begin
    rx = 1'b1;
    bus.rd = 1'b0;
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(bus.valid), 0);
    check("reset_data", int'(bus.data), 0);
    clr_n = 1'b1;
    idle(10);

    // 0xA5 with latency measurement
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    check("a5_latency", int'(rise_cyc - c0), 155);
    check("a5_data", int'(bus.data), 'hA5);
    check("a5_valid", int'(bus.valid), 1);
    check("a5_overrun", int'(bus.overrun), 0);
    check("a5_fe", fe_count, 0);
    rd_pulse();
    check("a5_rd_clears", int'(bus.valid), 0);

    // 4-cycle glitch is rejected, next frame is clean
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    $display("glitch: valid=%0d fe_total=%0d", bus.valid, fe_count);
    check("glitch_valid", int'(bus.valid), 0);
    check("glitch_fe", fe_count, 0);
    send_frame(8'h3C, 1'b1);
    check("3c_data", int'(bus.data), 'h3C);
    check("3c_valid", int'(bus.valid), 1);
    rd_pulse();

    // framing error
    apply_reset();
    fe_base = fe_count;
    send_frame(8'h55, 1'b0);
    idle(4);
    check("55_fe_pulses", fe_count - fe_base, 1);
    check("55_valid", int'(bus.valid), 0);
    check("55_data", int'(bus.data), 0);

    // overrun, then read clears both
    apply_reset();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("ovr_data", int'(bus.data), 'h11);
    check("ovr_valid", int'(bus.valid), 1);
    check("ovr_flag", int'(bus.overrun), 1);
    rd_pulse();
    $display("rd after overrun: valid=%0d overrun=%0d", bus.valid, bus.overrun);
    check("ovr_rd_valid", int'(bus.valid), 0);
    check("ovr_rd_flag", int'(bus.overrun), 0);

    // read exactly on the completion edge of the second byte
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        idle(LAT - 1);
        bus.rd = 1'b1;
        idle(1);
        bus.rd = 1'b0;
      end
    join
    idle(4);
    check("rdsame_data", int'(bus.data), 'h22);
    check("rdsame_valid", int'(bus.valid), 1);
    check("rdsame_overrun", int'(bus.overrun), 0);

    // reset after the 4th data bit of 0xFF, then 0x81
    apply_reset();
    fe_base = fe_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(CPB / 2);
    apply_reset();
    $display("mid-frame reset: valid=%0d data=0x%02h", bus.valid, bus.data);
    check("abort_valid", int'(bus.valid), 0);
    send_frame(8'h81, 1'b1);
    idle(4);
    check("81_data", int'(bus.data), 'h81);
    check("81_valid", int'(bus.valid), 1);
    check("81_overrun", int'(bus.overrun), 0);
    check("81_fe", fe_count - fe_base, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
